// File: rtl/async_send_pkg.sv
// Shared state encoding and sizing helper for the async send arbiter.
package async_send_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] REL  = 2'd2;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// Reset-to-zero flop chain bringing a single asynchronous bit into the clk domain.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ff <= '0;
      else      ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/async_send_arb.sv
// Round-robin arbiter over NUM_CH producers feeding a 4-phase send/ack link,
// with a synchronised ack and a watchdog that flags an unresponsive consumer.
module async_send_arb
   import async_send_pkg::*;
#(
   parameter  int NUM_CH      = 4,
   parameter  int DATA_W      = 8,
   parameter  int SYNC_STAGES = 2,
   parameter  int TIMEOUT     = 16,
   localparam int CH_W        = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        ch_ready,
   output logic                     send,
   output logic [DATA_W-1:0]        data_out,
   output logic [CH_W-1:0]          chan_out,
   input  logic                     ack,
   output logic                     busy,
   output logic                     timeout_err,
   input  logic                     err_clr
);

   localparam int CNT_W = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit WD_EN = (TIMEOUT > 0);

   logic [NUM_CH-1:0][DATA_W-1:0] ch_word;
   logic                          ack_s;
   logic [1:0]                    state;
   logic [CH_W-1:0]               rr_ptr;
   logic [CNT_W-1:0]              cnt;
   logic [CH_W:0]                 pick_r;
   logic                          pick_ok;
   logic [CH_W-1:0]               pick;
   logic                          wd_hit;

   assign ch_word = ch_data;

   sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (ack),
      .q   (ack_s)
   );

   // Scan downwards so the lowest offset from rr_ptr is the one left standing.
   function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] v,
                                             input logic [CH_W-1:0]   p);
      logic [CH_W:0] r;
      int            idx;
      r = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = int'(p) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (v[CH_W'(idx)]) r = {1'b1, CH_W'(idx)};
      end
      return r;
   endfunction

   always_comb begin
      pick_r  = rr_pick(ch_valid, rr_ptr);
      pick_ok = pick_r[CH_W];
      pick    = pick_r[CH_W-1:0];
   end

   assign wd_hit = WD_EN && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         send        <= 1'b0;
         busy        <= 1'b0;
         ch_ready    <= '0;
         data_out    <= '0;
         chan_out    <= '0;
         rr_ptr      <= '0;
         cnt         <= '0;
         timeout_err <= 1'b0;
      end else begin
         ch_ready <= '0;
         // A timeout set later in this block overrides a same-cycle clear.
         if (err_clr) timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_ok && !ack_s) begin
                  data_out <= ch_word[pick];
                  chan_out <= pick;
                  send     <= 1'b1;
                  busy     <= 1'b1;
                  ch_ready <= NUM_CH'(1) << pick;
                  rr_ptr   <= (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + CH_W'(1);
                  cnt      <= '0;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (ack_s) begin
                  send  <= 1'b0;
                  cnt   <= '0;
                  state <= REL;
               end else if (wd_hit) begin
                  send        <= 1'b0;
                  timeout_err <= 1'b1;
                  cnt         <= '0;
                  state       <= REL;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            REL: begin
               if (!ack_s) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (wd_hit) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               send  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_async_send_arb.sv
// Directed + randomized bench for async_send_arb against a round-robin reference model.
module tb_async_send_arb;

   localparam int NC = 4;
   localparam int DW = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [NC-1:0]    ch_valid = '0;
   logic [NC*DW-1:0] ch_data;
   logic [NC-1:0]    ch_ready;
   logic             send;
   logic [DW-1:0]    data_out;
   logic [1:0]       chan_out;
   logic             ack = 1'b0;
   logic             busy;
   logic             timeout_err;
   logic             err_clr = 1'b0;

   logic [DW-1:0]    tb_data [NC];
   int               n_assert = 0;
   int               n_fail   = 0;
   int               m_ptr    = 0;

   always #5 clk = ~clk;

   always_comb begin
      ch_data = '0;
      for (int i = 0; i < NC; i++) ch_data[i*DW +: DW] = tb_data[i];
   end

   async_send_arb #(.NUM_CH(NC), .DATA_W(DW), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .ch_valid    (ch_valid),
      .ch_data     (ch_data),
      .ch_ready    (ch_ready),
      .send        (send),
      .data_out    (data_out),
      .chan_out    (chan_out),
      .ack         (ack),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference arbitration: first requesting channel at or after the pointer, modulo NC.
   function automatic int model_grant(input logic [NC-1:0] v, input int p);
      for (int k = 0; k < NC; k++)
         if (v[(p + k) % NC]) return (p + k) % NC;
      return -1;
   endfunction

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (ch_ready !== '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic xfer(input logic [NC-1:0] v, input bit hold, input int ack_dly, input int rel_dly);
      int            g;
      int            n;
      bit            ok;
      logic [DW-1:0] gd;
      ch_valid = v;
      g  = model_grant(v, m_ptr);
      gd = tb_data[g];
      wait_ready(ok);
      chk("grant_seen", 32'(ok), 1);
      chk("ch_ready", 32'(ch_ready), 32'(1) << g);
      chk("chan_out", 32'(chan_out), g);
      chk("data_out", 32'(data_out), 32'(gd));
      chk("send_up", 32'(send), 1);
      chk("busy_up", 32'(busy), 1);
      m_ptr = (g + 1) % NC;
      if (!hold) ch_valid[g] = 1'b0;
      tb_data[g] = 8'($urandom);
      tick();
      chk("ready_pulse", 32'(ch_ready), 0);
      repeat (ack_dly) tick();
      ack = 1'b1;
      n = 0;
      do begin tick(); n++; end while (send === 1'b1 && n < 20);
      chk("ack_to_send_fall", n, 3);
      repeat (rel_dly) tick();
      ack = 1'b0;
      n = 0;
      do begin tick(); n++; end while (busy === 1'b1 && n < 20);
      chk("ack_fall_to_idle", n, 3);
      chk("data_hold", 32'(data_out), 32'(gd));
      chk("chan_hold", 32'(chan_out), g);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  g;
      bit  ok;
      for (int i = 0; i < NC; i++) tb_data[i] = 8'($urandom);

      // reset state
      tick(); tick();
      chk("rst_send", 32'(send), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(ch_ready), 0);
      chk("rst_data", 32'(data_out), 0);
      chk("rst_chan", 32'(chan_out), 0);
      chk("rst_err", 32'(timeout_err), 0);
      @(negedge clk) rst = 1'b1;

      // single word on channel 2
      tb_data[2] = 8'hA5;
      xfer(4'b0100, 1'b0, 2, 1);

      // round-robin from a fresh pointer
      rst = 1'b0; #3; @(negedge clk) rst = 1'b1;
      m_ptr = 0;
      for (int i = 0; i < 6; i++) begin
         chk("rr_order", model_grant(4'b1111, m_ptr), i % NC);
         xfer(4'b1111, 1'b1, i % 3, i % 2);
      end

      // wrap: move pointer to 3, then 1001 grants 3 then 0, then 0001 alone
      xfer(4'b0100, 1'b0, 0, 0);
      chk("ptr_at_3", m_ptr, 3);
      xfer(4'b1001, 1'b0, 1, 0);
      xfer(ch_valid, 1'b0, 1, 0);
      xfer(4'b0001, 1'b0, 0, 1);

      // REQ timeout with ack held low
      ch_valid = 4'b0010;
      g = model_grant(ch_valid, m_ptr);
      wait_ready(ok);
      chk("to_grant", 32'(ok), 1);
      chk("to_chan", 32'(chan_out), g);
      m_ptr = (g + 1) % NC;
      ch_valid = '0;
      repeat (15) tick();
      chk("to_send_held", 32'(send), 1);
      tick();
      chk("to_send_drop", 32'(send), 0);
      chk("to_err_set", 32'(timeout_err), 1);
      chk("to_busy_rel", 32'(busy), 1);
      tick();
      chk("to_idle", 32'(busy), 0);
      chk("to_err_sticky", 32'(timeout_err), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr", 32'(timeout_err), 0);

      // REL timeout with ack stuck high; same-edge clear loses to the new timeout
      ch_valid = 4'b0001;
      g = model_grant(ch_valid, m_ptr);
      wait_ready(ok);
      chk("rel_grant", 32'(ok), 1);
      chk("rel_chan", 32'(chan_out), g);
      m_ptr = (g + 1) % NC;
      ch_valid = '0;
      ack = 1'b1;
      repeat (3) tick();
      chk("rel_send_drop", 32'(send), 0);
      repeat (15) tick();
      chk("rel_busy_held", 32'(busy), 1);
      err_clr = 1'b1;
      tick();
      chk("rel_busy_drop", 32'(busy), 0);
      chk("rel_err_wins", 32'(timeout_err), 1);
      tick();
      err_clr = 1'b0;
      chk("rel_err_clr", 32'(timeout_err), 0);

      // spurious ack in IDLE blocks grants
      ch_valid = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("spur_no_ready", 32'(ch_ready), 0);
         chk("spur_no_send", 32'(send), 0);
      end
      ack = 1'b0;
      xfer(4'b0010, 1'b0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 20; i++)
         xfer(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 8), $urandom_range(0, 8));

      // asynchronous reset in the middle of a request
      ch_valid = 4'b0100;
      wait_ready(ok);
      chk("mid_grant", 32'(ok), 1);
      ch_valid = 4'b1010;
      #2 rst = 1'b0;
      #1;
      chk("mid_send", 32'(send), 0);
      chk("mid_busy", 32'(busy), 0);
      chk("mid_ready", 32'(ch_ready), 0);
      chk("mid_data", 32'(data_out), 0);
      chk("mid_chan", 32'(chan_out), 0);
      m_ptr = 0;
      @(negedge clk) rst = 1'b1;
      xfer(4'b1010, 1'b0, 1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
